dmem_bridge: RTL
================

// Module: dmem_bridge
// PURPOSE
//   Sits between the datapath dmem request/response port and a 32-bit word-only synchronous data SRAM.
//   Handles the sub-word work the SRAM cannot: byte strobes and lane replication on stores,
//   and lane extraction with sign/zero extension on loads.
//   Detects misaligned or illegal-width accesses, runs one request at a time, and hides the SRAM read latency.
// PARAMETERS
//   MEM_LATENCY  1  cycles from mem_en (read) to valid mem_rdata; legal values are >=1
// PORTS
//   clk               in   1   single clock; all state changes on the rising edge
//   reset             in   1   asynchronous, active-low reset (0 = in reset)
//   req_valid         in   1   datapath presents a request
//   req_addr          in   32  byte address
//   req_write_enable  in   1   1 = store, 0 = load
//   req_write_data    in   32  store data, right-aligned
//   req_data_width    in   3   funct3 code: 000=B, 001=H, 010=W, 100=BU, 101=HU
//   req_ready         out  1   bridge can accept a request this cycle
//   resp_valid        out  1   one-cycle pulse: the request has completed
//   resp_data         out  32  load result, extended; 0 for stores and errors
//   resp_misaligned   out  1   qualified by resp_valid: the access was rejected
//   mem_en            out  1   SRAM access strobe
//   mem_we            out  1   SRAM write enable
//   mem_wstrb         out  4   byte write strobes; bit i covers wdata[8i+7:8i]
//   mem_addr          out  30  word address, = req_addr[31:2]
//   mem_wdata         out  32  lane-replicated store data
//   mem_rdata         in   32  SRAM read word
// BEHAVIOUR
//   Reset (reset=0): state goes to IDLE immediately, asynchronously.
//     - All outputs read 0, including req_ready, while reset is held.
//     - Any in-flight access is dropped: no resp_valid, no write.
//   FSM states: IDLE, ACCESS, WAIT, RESP.
//     - req_ready = 1 only in IDLE.
//     - req_valid outside IDLE is ignored; the bridge does not queue requests.
//   Handshake: a request is accepted in cycle T when req_valid && req_ready.
//     - All req_* inputs are latched at T.
//     - Legal request: next state is ACCESS.
//     - Illegal request: next state is RESP with resp_misaligned=1.
//   What makes a request illegal:
//     - H/HU with addr[0] != 0.
//     - W with addr[1:0] != 0.
//     - Width code 011, 110 or 111.
//     - Stores use only width codes 000/001/010. A store with code 1xx is illegal.
//     - An illegal request never drives mem_en.
//   ACCESS lasts exactly 1 cycle (T+1).
//     - mem_en=1; mem_we = the latched write_enable; mem_addr/mem_wdata/mem_wstrb are valid.
//     - Outside ACCESS: mem_en=0, mem_we=0, mem_wstrb=0.
//     - Store: next state is RESP, so resp_valid is high at T+2.
//     - Load: next state is WAIT.
//   WAIT lasts MEM_LATENCY cycles, counted down from MEM_LATENCY-1 to 0.
//     - On the edge leaving the last WAIT cycle (the one in which count==0), mem_rdata is
//       extracted and registered into resp_data, and the state moves to RESP.
//     - Load resp_valid is therefore high at T+2+MEM_LATENCY.
//   RESP lasts 1 cycle: resp_valid=1, then the state returns to IDLE.
//     - There is no back-pressure: the datapath must take the response.
//     - resp_data and resp_misaligned hold their values until the next RESP.
//   Store lanes, with o = addr[1:0]:
//     - B: mem_wstrb = 1<<o; mem_wdata = {4{wd[7:0]}}.
//     - H: mem_wstrb = o[1] ? 1100 : 0011; mem_wdata = {2{wd[15:0]}}.
//     - W: mem_wstrb = 1111; mem_wdata = wd.
//   Load extraction: lane = mem_rdata >> (8*o).
//     - B and H sign-extend lane[7:0] and lane[15:0] respectively.
//     - BU and HU zero-extend; W passes the word unchanged.
//   Reset asserted mid-ACCESS, mid-WAIT or mid-RESP aborts the access.
//     - After reset is released, the first request is served normally.
// TESTING
//   1. Hold reset=0 for 3 cycles -> every output is 0; after release, req_ready=1 the next cycle.
//   2. SW addr=0x100, data=0xDEADBEEF -> at T+1: mem_en=1, we=1, addr=0x40, wstrb=1111,
//      wdata=0xDEADBEEF; at T+2: resp_valid=1, resp_misaligned=0.
//   3. SB addr=0x103, data=0x000000A5 -> wstrb=1000, wdata=0xA5A5A5A5.
//      SH addr=0x102, data=0x1234 -> wstrb=1100, wdata=0x12341234.
//   4. MEM_LATENCY=1, mem_rdata=0x80FF7F00:
//      LB addr 0x102 -> 0xFFFFFFFF; LBU addr 0x102 -> 0x000000FF;
//      LH addr 0x102 -> 0xFFFF80FF; LB addr 0x101 -> 0x0000007F.
//      In each case resp_valid is high at T+3.
//   5. LW addr=0x101 -> mem_en stays 0; at T+1: resp_valid=1, resp_misaligned=1, resp_data=0.
//      A second req_valid held during T+1 is not accepted.
//   6. MEM_LATENCY=3, LW issued, reset pulsed low during WAIT -> no resp_valid and no mem_we
//      ever; a following LW addr 0x0 returns mem_rdata at T+5.

Source files
------------

// File: rtl/dmem_bridge.sv
// Bridge between the datapath dmem port and a 32-bit word-only synchronous SRAM.
// Adds byte strobes/lane replication on stores and lane extraction with extension on loads.
module dmem_bridge #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic        req_write_enable,
    input  logic [31:0] req_write_data,
    input  logic [2:0]  req_data_width,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_misaligned,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [2:0] W_B  = 3'b000;
    localparam logic [2:0] W_H  = 3'b001;
    localparam logic [2:0] W_W  = 3'b010;
    localparam logic [2:0] W_BU = 3'b100;
    localparam logic [2:0] W_HU = 3'b101;

    localparam int            CW       = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);

    logic [1:0]    state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic          we_q, we_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [2:0]    width_q, width_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   resp_data_q, resp_data_d;
    logic          resp_mis_q, resp_mis_d;

    logic [3:0]    lane_strb;
    logic [31:0]   lane_wdata;
    logic [31:0]   rd_lane;
    logic [31:0]   load_data;

    // Loads accept all five widths; stores only the signed codes, which also fix the size.
    function automatic logic is_illegal(input logic we, input logic [2:0] w, input logic [1:0] o);
        logic bad;
        case (w)
            W_B:     bad = 1'b0;
            W_H:     bad = o[0];
            W_W:     bad = (o != 2'b00);
            W_BU:    bad = we;
            W_HU:    bad = we | o[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    always_comb begin
        // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
        lane_strb  = 4'b0000;
        lane_wdata = 32'h0;
        case (width_q[1:0])
            2'b00: begin
                lane_strb  = 4'b0001 << addr_q[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_strb  = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                lane_strb  = 4'b1111;
                lane_wdata = wdata_q;
            end
        endcase
    end

    always_comb begin
        rd_lane   = mem_rdata >> {addr_q[1:0], 3'b000};
        load_data = mem_rdata;
        case (width_q)
            W_B:     load_data = {{24{rd_lane[7]}}, rd_lane[7:0]};
            W_H:     load_data = {{16{rd_lane[15]}}, rd_lane[15:0]};
            W_BU:    load_data = {24'h0, rd_lane[7:0]};
            W_HU:    load_data = {16'h0, rd_lane[15:0]};
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        width_d     = width_q;
        cnt_d       = cnt_q;
        resp_data_d = resp_data_q;
        resp_mis_d  = resp_mis_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    we_d    = req_write_enable;
                    wdata_d = req_write_data;
                    width_d = req_data_width;
                    if (is_illegal(req_write_enable, req_data_width, req_addr[1:0])) begin
                        state_d     = S_RESP;
                        resp_data_d = 32'h0;
                        resp_mis_d  = 1'b1;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                if (we_q) begin
                    state_d     = S_RESP;
                    resp_data_d = 32'h0;
                    resp_mis_d  = 1'b0;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            S_WAIT: begin
                // The SRAM word is valid only in the last WAIT cycle; capture it on the way out.
                if (cnt_q == '0) begin
                    state_d     = S_RESP;
                    resp_data_d = load_data;
                    resp_mis_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            addr_q      <= 32'h0;
            we_q        <= 1'b0;
            wdata_q     <= 32'h0;
            width_q     <= 3'b000;
            cnt_q       <= '0;
            resp_data_q <= 32'h0;
            resp_mis_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            width_q     <= width_d;
            cnt_q       <= cnt_d;
            resp_data_q <= resp_data_d;
            resp_mis_q  <= resp_mis_d;
        end
    end

    // req_ready is gated by reset so the port reads idle-but-not-ready while reset is held.
    assign req_ready       = reset & (state_q == S_IDLE);
    assign resp_valid      = (state_q == S_RESP);
    assign resp_data       = resp_data_q;
    assign resp_misaligned = resp_mis_q;
    assign mem_en          = (state_q == S_ACCESS);
    assign mem_we          = mem_en & we_q;
    assign mem_wstrb       = (mem_en & we_q) ? lane_strb : 4'b0000;
    assign mem_addr        = addr_q[31:2];
    assign mem_wdata       = lane_wdata;

endmodule
